// File: rtl/mill_modif_mod.sv
// Modified Miller encoder, PCD->PICC, ISO/IEC 14443 Type A at 106 kbit/s.
// Frames bytes with SoC, odd parity and EoC and drives the carrier pause as X/Y/Z cells.
module mill_modif_mod #(
    parameter int unsigned ETU_CLK   = 32,
    parameter int unsigned PAUSE_CLK = 8
) (
    input  logic       clk,
    input  logic       in_PoR,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_short,
    output logic       out_ready,
    output logic       out_pause,
    output logic       out_busy,
    output logic       out_err
);

    localparam int unsigned CW  = $clog2(ETU_CLK);
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ETU_CLK - 1);
    localparam logic [CW:0]   Z_END    = CW1'(PAUSE_CLK);
    localparam logic [CW:0]   X_BEG    = CW1'(ETU_CLK / 2);
    localparam logic [CW:0]   X_END    = CW1'(ETU_CLK / 2 + PAUSE_CLK);

    typedef enum logic [2:0] {
        StIdle, StSoc, StData, StParity, StEoc0, StEocy
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          par_q, par_d;
    logic          short_q, short_d;
    logic          cur_last_q, cur_last_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;
    logic          prev_zero_q, prev_zero_d;
    logic          pause_q, pause_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic          tick, accept, start, bypass, hold_load;
    logic          cell_bit, is_z, is_x;
    logic [CW:0]   cnt_w;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        accept   = in_valid & ready_q;
        start    = accept & ((state_q == StIdle) | ((state_q == StEocy) & tick));
        // A byte handed over on the last parity edge with the holding register empty
        // goes straight into the shift register so the next data cell follows without a gap.
        bypass   = accept & (state_q == StParity) & tick & ~cur_last_q & ~hold_full_q;
        hold_load = accept & ~start & ~bypass;
        cnt_w    = {1'b0, cnt_q};

        cell_bit = 1'b0;
        is_z     = 1'b0;
        is_x     = 1'b0;
        unique case (state_q)
            StSoc:    is_z = 1'b1;
            StData:   cell_bit = shift_q[0];
            StParity: cell_bit = par_q;
            default:  ;
        endcase
        if ((state_q == StData) || (state_q == StParity) || (state_q == StEoc0)) begin
            is_x = cell_bit;
            is_z = ~cell_bit & prev_zero_q;
        end
        pause_d = (is_z & (cnt_w < Z_END)) | (is_x & (cnt_w >= X_BEG) & (cnt_w < X_END));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == StIdle) ? '0 : (tick ? '0 : cnt_q + 1'b1);
        shift_d     = shift_q;
        bit_d       = bit_q;
        par_d       = par_q;
        short_d     = short_q;
        cur_last_d  = cur_last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        prev_zero_d = prev_zero_q;
        err_d       = 1'b0;

        if (hold_load) begin
            hold_d      = in_byte;
            hold_last_d = in_last;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSoc;
            end
            StSoc: begin
                if (tick) begin
                    state_d     = StData;
                    prev_zero_d = 1'b1;
                end
            end
            StData: begin
                if (tick) begin
                    prev_zero_d = ~cell_bit;
                    shift_d     = shift_q >> 1;
                    bit_d       = bit_q + 3'd1;
                    if (bit_q == (short_q ? 3'd6 : 3'd7)) begin
                        state_d = short_q ? StEoc0 : StParity;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    prev_zero_d = ~par_q;
                    if (cur_last_q) begin
                        state_d = StEoc0;
                    end else if (hold_full_q) begin
                        state_d     = StData;
                        shift_d     = hold_q;
                        par_d       = ~^hold_q;
                        bit_d       = 3'd0;
                        short_d     = 1'b0;
                        cur_last_d  = hold_last_q;
                        hold_full_d = 1'b0;
                    end else if (bypass) begin
                        state_d    = StData;
                        shift_d    = in_byte;
                        par_d      = ~^in_byte;
                        bit_d      = 3'd0;
                        short_d    = 1'b0;
                        cur_last_d = in_last;
                    end else begin
                        state_d = StEoc0;
                        err_d   = 1'b1;
                    end
                end
            end
            StEoc0: begin
                if (tick) begin
                    state_d     = StEocy;
                    prev_zero_d = 1'b1;
                end
            end
            StEocy: begin
                if (tick) state_d = start ? StSoc : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            cnt_d      = '0;
            shift_d    = in_byte;
            par_d      = ~^in_byte;
            bit_d      = 3'd0;
            short_d    = in_short;
            cur_last_d = in_last | in_short;
        end
    end

    always_comb begin
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StIdle:           ready_d = 1'b1;
            StData, StParity: ready_d = ~hold_full_d & ~cur_last_d;
            // Lets a new frame start on the very edge that ends the current one.
            StEocy:           ready_d = (cnt_d == CNT_LAST);
            default:          ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge in_PoR) begin
        if (!in_PoR) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            par_q       <= 1'b0;
            short_q     <= 1'b0;
            cur_last_q  <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            prev_zero_q <= 1'b0;
            pause_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            par_q       <= par_d;
            short_q     <= short_d;
            cur_last_q  <= cur_last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            prev_zero_q <= prev_zero_d;
            pause_q     <= pause_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign out_pause = pause_q;
    assign out_busy  = busy_q;
    assign out_ready = ready_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mill_modif_mod.sv
// Bench for mill_modif_mod: expected cell patterns are queued when a frame is offered and
// compared, one bit cell at a time, as the encoder plays them out.
module tb_mill_modif_mod;

    localparam int ETU   = 32;
    localparam int PAUSE = 8;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       in_PoR;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       in_short;
    logic       out_ready;
    logic       out_pause;
    logic       out_busy;
    logic       out_err;

    mill_modif_mod #(
        .ETU_CLK   (ETU),
        .PAUSE_CLK (PAUSE)
    ) dut (
        .clk       (clk),
        .in_PoR    (in_PoR),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_short  (in_short),
        .out_ready (out_ready),
        .out_pause (out_pause),
        .out_busy  (out_busy),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       shrt;
    } tx_t;

    tx_t            txq[$];
    logic [ETU-1:0] expq[$];
    logic [ETU-1:0] pat_z, pat_x, cell_buf;

    int n_assert = 0;
    int n_fail   = 0;
    bit collecting = 1'b0;
    int samp_idx = 0;
    int cell_idx = 0;
    int clk_idx  = 0;
    int busy_cnt = 0;
    int err_cnt  = 0;
    int err_at   = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        if (txq.size() > 0) begin
            in_valid = 1'b1;
            in_byte  = txq[0].b;
            in_last  = txq[0].last;
            in_short = txq[0].shrt;
        end else begin
            in_valid = 1'b0;
            in_byte  = 8'h00;
            in_last  = 1'b0;
            in_short = 1'b0;
        end
    endtask

    // One clock: sample just after the edge, compare completed cells, advance the byte feeder.
    task automatic tick();
        logic acc, was_idle;
        acc      = in_valid && out_ready;
        was_idle = !out_busy;
        @(posedge clk);
        #1;
        clk_idx++;
        if (collecting) begin
            cell_buf[samp_idx] = out_pause;
            samp_idx++;
            if (samp_idx == ETU) begin
                samp_idx = 0;
                check($sformatf("cell%0d", cell_idx), cell_buf, expq.pop_front());
                cell_idx++;
                if (expq.size() == 0) collecting = 1'b0;
            end
        end
        if (acc && was_idle) begin
            collecting = (expq.size() > 0);
            samp_idx   = 0;
            cell_idx   = 0;
            clk_idx    = 0;
            busy_cnt   = 0;
            err_cnt    = 0;
            err_at     = -1;
        end
        if (out_busy) busy_cnt++;
        if (out_err) begin
            err_cnt++;
            err_at = clk_idx;
        end
        if (acc) void'(txq.pop_front());
        drive_inputs();
    endtask

    task automatic enc(input bit v, inout bit pz);
        if (v) begin
            expq.push_back(pat_x);
            pz = 1'b0;
        end else begin
            expq.push_back(pz ? pat_z : '0);
            pz = 1'b1;
        end
    endtask

    // Reference coding of a whole frame, pushed as expected cell patterns.
    task automatic add_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n, input bit shrt, input bit last_f);
        bit         pz;
        logic [7:0] cur;
        expq.push_back(pat_z);
        pz = 1'b1;
        if (shrt) begin
            for (int i = 0; i < 7; i++) enc(b0[i], pz);
        end else begin
            for (int k = 0; k < n; k++) begin
                cur = (k == 0) ? b0 : ((k == 1) ? b1 : b2);
                for (int i = 0; i < 8; i++) enc(cur[i], pz);
                enc(~^cur, pz);
            end
        end
        enc(1'b0, pz);
        expq.push_back('0);
        for (int k = 0; k < n; k++) begin
            cur = (k == 0) ? b0 : ((k == 1) ? b1 : b2);
            txq.push_back({cur, (k == n - 1) ? last_f : 1'b0, (k == 0) ? shrt : 1'b0});
        end
        drive_inputs();
    endtask

    task automatic run_frame(input string tag, input int exp_busy, input int exp_err,
                             input int exp_err_at);
        int guard = 0;
        while ((collecting || out_busy || txq.size() > 0) && guard < LIMIT) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, (guard < LIMIT && expq.size() == 0), 1);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_errcnt"}, err_cnt, exp_err);
        check({tag, "_errat"}, err_at, exp_err_at);
        repeat (4) tick();
    endtask

    task automatic run_until(input int idx);
        int guard = 0;
        while (!(collecting && clk_idx == idx) && guard < LIMIT) begin
            tick();
            guard++;
        end
        check("reach_point", guard < LIMIT, 1);
    endtask

    initial begin
        pat_z = '0;
        pat_x = '0;
        for (int m = 0; m < PAUSE; m++) begin
            pat_z[m]         = 1'b1;
            pat_x[ETU/2 + m] = 1'b1;
        end
        in_PoR = 1'b0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pause", out_pause, 0);
        check("rst_busy", out_busy, 0);
        check("rst_ready", out_ready, 1);
        check("rst_err", out_err, 0);
        in_PoR = 1'b1;
        repeat (2) tick();

        // REQA short frame
        add_frame(8'h26, 8'h00, 8'h00, 1, 1'b1, 1'b1);
        run_frame("reqa", 10 * ETU, 0, -1);

        // Single byte, last
        add_frame(8'h93, 8'h00, 8'h00, 1, 1'b0, 1'b1);
        run_frame("b93", 12 * ETU, 0, -1);

        // Two bytes back to back, valid held
        add_frame(8'h93, 8'h20, 8'h00, 2, 1'b0, 1'b1);
        run_frame("b93_20", 21 * ETU, 0, -1);

        // Underrun after a non-last byte
        add_frame(8'h55, 8'h00, 8'h00, 1, 1'b0, 1'b0);
        run_frame("under", 12 * ETU, 1, 10 * ETU);

        // Backpressure: third byte waits on the bus while holding is full
        add_frame(8'h93, 8'h20, 8'h55, 3, 1'b0, 1'b1);
        run_until(100);
        check("bp_ready", out_ready, 0);
        run_frame("bp", 30 * ETU, 0, -1);

        // Asynchronous reset during an X pause
        add_frame(8'h93, 8'h00, 8'h00, 1, 1'b0, 1'b1);
        run_until(50);
        check("pre_rst_pause", out_pause, 1);
        #2;
        in_PoR = 1'b0;
        #1;
        check("arst_pause", out_pause, 0);
        check("arst_busy", out_busy, 0);
        check("arst_ready", out_ready, 1);
        expq.delete();
        txq.delete();
        collecting = 1'b0;
        drive_inputs();
        repeat (3) tick();
        check("arst_hold_busy", out_busy, 0);
        in_PoR = 1'b1;
        repeat (2) tick();
        add_frame(8'h26, 8'h00, 8'h00, 1, 1'b1, 1'b1);
        run_frame("reqa2", 10 * ETU, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
